// File: rtl/tt_if_pkg.sv
// -----------------------------------------------------------------------------
// tt_if_pkg
// Shared types and helpers for the TinyTapeout interface multiplexer.
//   state_t     : switch sequencer states
//   cnt_width() : width of the DRAIN/HOLD duration counter
//   byte_slice(): pull project i's byte out of a flattened per-project bus
// -----------------------------------------------------------------------------
package tt_if_pkg;

    // Upper bound on attached projects; the flattened buses are zero-extended
    // to this width so one helper serves every N_PROJECTS value.
    localparam int MAX_PROJECTS = 16;
    localparam int BUS_W        = MAX_PROJECTS * 8;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DRAIN,
        ST_HOLD,
        ST_START,
        ST_ACTIVE
    } state_t;

    // Bits needed to count up to the longer of the two timed phases.
    function automatic int cnt_width(input int rst_hold, input int drain_cyc);
        int longest;
        longest = (rst_hold > drain_cyc) ? rst_hold : drain_cyc;
        return $clog2(longest + 1);
    endfunction

    function automatic logic [7:0] byte_slice(input logic [BUS_W-1:0] bus,
                                              input logic [3:0]       idx);
        return bus[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/tt_clk_div.sv
// -----------------------------------------------------------------------------
// tt_clk_div
// Divided project clock: clk_out toggles every (div+1) clk cycles while en is
// high. restart or !en clears the counter and forces clk_out low.
//   clk      in   fabric clock
//   rst_n    in   synchronous active-low reset
//   en       in   divider running
//   restart  in   restart from count 0 with clk_out low
//   div      in   divide setting
//   clk_out  out  registered divided clock
// -----------------------------------------------------------------------------
module tt_clk_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (restart || !en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (cnt == div) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_if_mux.sv
// -----------------------------------------------------------------------------
// tt_if_mux
// Multiplexes N_PROJECTS TinyTapeout projects onto one fabric ui/uo/uio port
// set and sequences project switches: disable, drain, hold reset, release,
// enable. Both I/O directions are registered once.
//   UserCLK, RST_N           clock, synchronous active-low reset
//   sel_req/valid/ready      project select handshake
//   div_cfg                  project clock divider, captured at acceptance
//   fab_*                    fabric-side ports
//   prj_*                    project-side ports (flattened, project i at [8i+7:8i])
//   active_sel, busy, sel_err  status
// -----------------------------------------------------------------------------
module tt_if_mux
    import tt_if_pkg::*;
#(
    parameter int N_PROJECTS = 4,
    parameter int SEL_W      = 4,
    parameter int RST_HOLD   = 8,
    parameter int DRAIN_CYC  = 2,
    parameter int DIV_W      = 4
) (
    input  logic                    UserCLK,
    input  logic                    RST_N,
    input  logic [SEL_W-1:0]        sel_req,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    input  logic [DIV_W-1:0]        div_cfg,
    input  logic [7:0]              fab_ui_in,
    input  logic [7:0]              fab_uio_in,
    output logic [7:0]              fab_uo_out,
    output logic [7:0]              fab_uio_out,
    output logic [7:0]              fab_uio_oe,
    input  logic [N_PROJECTS*8-1:0] prj_uo_out,
    input  logic [N_PROJECTS*8-1:0] prj_uio_out,
    input  logic [N_PROJECTS*8-1:0] prj_uio_oe,
    output logic [7:0]              prj_ui_in,
    output logic [7:0]              prj_uio_in,
    output logic [N_PROJECTS-1:0]   prj_ena,
    output logic [N_PROJECTS-1:0]   prj_rst_n,
    output logic                    prj_clk,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    busy,
    output logic                    sel_err
);

    localparam int               CNT_W      = cnt_width(RST_HOLD, DRAIN_CYC);
    localparam logic [SEL_W:0]   N_LIMIT    = (SEL_W+1)'(N_PROJECTS);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] pend_sel;
    logic [DIV_W-1:0] div_latched;
    logic             accept, req_ok, pend_ok, enter_hold, pass;
    logic [3:0]       sel_idx;

    assign accept     = sel_valid & sel_ready;
    assign req_ok     = {1'b0, sel_req}  < N_LIMIT;
    assign pend_ok    = {1'b0, pend_sel} < N_LIMIT;
    assign enter_hold = (state_next == ST_HOLD) && (state != ST_HOLD);
    // Outputs pass only while staying in ACTIVE, so forcing to 0 lands on the
    // same registered cycle as the transition out of ACTIVE.
    assign pass       = (state == ST_ACTIVE) && (state_next == ST_ACTIVE);
    assign sel_idx    = 4'(active_sel);

    // ---------------- state register ----------------
    always_ff @(posedge UserCLK) begin
        if (!RST_N) state <= ST_OFF;
        else        state <= state_next;
    end

    // ---------------- next state ----------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_OFF:    if (accept) state_next = req_ok ? ST_HOLD : ST_DRAIN;
            ST_ACTIVE: if (accept) state_next = ST_DRAIN;
            ST_DRAIN:  if (cnt == DRAIN_LAST) state_next = pend_ok ? ST_HOLD : ST_OFF;
            ST_HOLD:   if (cnt == HOLD_LAST) state_next = ST_START;
            ST_START:  state_next = ST_ACTIVE;
            default:   state_next = ST_OFF;
        endcase
    end

    // ---------------- outputs from state ----------------
    always_comb begin
        sel_ready = (state == ST_OFF) || (state == ST_ACTIVE);
        busy      = (state == ST_DRAIN) || (state == ST_HOLD) || (state == ST_START);
        prj_ena   = '0;
        prj_rst_n = '0;
        for (int i = 0; i < N_PROJECTS; i++) begin
            if (active_sel == SEL_W'(i)) begin
                prj_ena[i]   = (state == ST_ACTIVE);
                prj_rst_n[i] = (state == ST_START) || (state == ST_ACTIVE);
            end
        end
    end

    // ---------------- sequencer bookkeeping ----------------
    always_ff @(posedge UserCLK) begin
        if (!RST_N) begin
            cnt         <= '0;
            pend_sel    <= '0;
            div_latched <= '0;
            active_sel  <= '0;
            sel_err     <= 1'b0;
        end else begin
            // Phase counter restarts on every state change.
            if (state_next != state) cnt <= '0;
            else if (busy)           cnt <= cnt + 1'b1;

            if (accept) begin
                pend_sel    <= sel_req;
                div_latched <= div_cfg;
                sel_err     <= !req_ok;
            end

            // From OFF the request goes straight to HOLD, so pend_sel is not
            // loaded yet; take the index from the request itself.
            if (enter_hold) active_sel <= (state == ST_OFF) ? sel_req : pend_sel;
        end
    end

    // ---------------- registered I/O ----------------
    always_ff @(posedge UserCLK) begin
        if (!RST_N) begin
            prj_ui_in   <= '0;
            prj_uio_in  <= '0;
            fab_uo_out  <= '0;
            fab_uio_out <= '0;
            fab_uio_oe  <= '0;
        end else begin
            prj_ui_in   <= fab_ui_in;
            prj_uio_in  <= fab_uio_in;
            fab_uo_out  <= pass ? byte_slice(BUS_W'(prj_uo_out),  sel_idx) : 8'h00;
            fab_uio_out <= pass ? byte_slice(BUS_W'(prj_uio_out), sel_idx) : 8'h00;
            fab_uio_oe  <= pass ? byte_slice(BUS_W'(prj_uio_oe),  sel_idx) : 8'h00;
        end
    end

    // ---------------- project clock ----------------
    // Enable follows the next state so the clock drops low on the same edge
    // that enters DRAIN or OFF.
    tt_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk     (UserCLK),
        .rst_n   (RST_N),
        .en      ((state_next == ST_HOLD) || (state_next == ST_START) ||
                  (state_next == ST_ACTIVE)),
        .restart (enter_hold),
        .div     (div_latched),
        .clk_out (prj_clk)
    );

endmodule

// File: tb/tb_tt_if_mux.sv
// -----------------------------------------------------------------------------
// tb_tt_if_mux
// Self-checking bench for tt_if_mux (4 projects). Each switch request pushes
// its expected per-cycle trace onto a scoreboard queue; the trace is popped
// and compared against the DUT one cycle at a time.
// -----------------------------------------------------------------------------
module tb_tt_if_mux;

    localparam int N         = 4;
    localparam int SEL_W     = 4;
    localparam int RST_HOLD  = 8;
    localparam int DRAIN_CYC = 2;
    localparam int DIV_W     = 4;

    localparam logic [31:0] UO_PAT  = 32'hC396_A51E;
    localparam logic [31:0] UIO_PAT = 32'h4433_2211;
    localparam logic [31:0] OE_PAT  = 32'hF00F_CC33;

    logic             UserCLK = 1'b0;
    logic             RST_N;
    logic [SEL_W-1:0] sel_req;
    logic             sel_valid;
    logic             sel_ready;
    logic [DIV_W-1:0] div_cfg;
    logic [7:0]       fab_ui_in, fab_uio_in;
    logic [7:0]       fab_uo_out, fab_uio_out, fab_uio_oe;
    logic [N*8-1:0]   prj_uo_out, prj_uio_out, prj_uio_oe;
    logic [7:0]       prj_ui_in, prj_uio_in;
    logic [N-1:0]     prj_ena, prj_rst_n;
    logic             prj_clk;
    logic [SEL_W-1:0] active_sel;
    logic             busy, sel_err;

    assign prj_uo_out  = UO_PAT;
    assign prj_uio_out = UIO_PAT;
    assign prj_uio_oe  = OE_PAT;

    tt_if_mux #(
        .N_PROJECTS (N),
        .SEL_W      (SEL_W),
        .RST_HOLD   (RST_HOLD),
        .DRAIN_CYC  (DRAIN_CYC),
        .DIV_W      (DIV_W)
    ) dut (
        .UserCLK     (UserCLK),
        .RST_N       (RST_N),
        .sel_req     (sel_req),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .div_cfg     (div_cfg),
        .fab_ui_in   (fab_ui_in),
        .fab_uio_in  (fab_uio_in),
        .fab_uo_out  (fab_uo_out),
        .fab_uio_out (fab_uio_out),
        .fab_uio_oe  (fab_uio_oe),
        .prj_uo_out  (prj_uo_out),
        .prj_uio_out (prj_uio_out),
        .prj_uio_oe  (prj_uio_oe),
        .prj_ui_in   (prj_ui_in),
        .prj_uio_in  (prj_uio_in),
        .prj_ena     (prj_ena),
        .prj_rst_n   (prj_rst_n),
        .prj_clk     (prj_clk),
        .active_sel  (active_sel),
        .busy        (busy),
        .sel_err     (sel_err)
    );

    always #5 UserCLK = ~UserCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    typedef struct {
        string      tag;
        int         cyc;
        logic [3:0] ena;
        logic [3:0] rstn;
        bit         rstn_chk;
        logic       busy;
        logic       ready;
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
        logic       clk;
        logic       err;
        logic [3:0] sel;
        bit         sel_chk;
    } exp_t;

    exp_t sb[$];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] last_ui, last_uio;
    bit         ui_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input logic [31:0] pat, input int idx);
        logic [31:0] p;
        p = pat;
        return p[idx*8 +: 8];
    endfunction

    // One UserCLK cycle; outputs sampled on the falling edge. Also checks the
    // one-stage fabric -> project input path with fresh random data.
    task automatic tick();
        @(posedge UserCLK);
        @(negedge UserCLK);
        if (ui_known) begin
            check("ui_in",  32'(prj_ui_in),  32'(last_ui));
            check("uio_in", 32'(prj_uio_in), 32'(last_uio));
        end
        last_ui    = 8'($urandom);
        last_uio   = 8'($urandom);
        fab_ui_in  = last_ui;
        fab_uio_in = last_uio;
        ui_known   = 1'b1;
    endtask

    task automatic apply_reset(input string tag);
        RST_N     = 1'b0;
        sel_valid = 1'b0;
        ui_known  = 1'b0;
        tick();
        check({tag, ".ena"},     32'(prj_ena),     32'd0);
        check({tag, ".rst_n"},   32'(prj_rst_n),   32'd0);
        check({tag, ".busy"},    32'(busy),        32'd0);
        check({tag, ".ready"},   32'(sel_ready),   32'd1);
        check({tag, ".err"},     32'(sel_err),     32'd0);
        check({tag, ".uo"},      32'(fab_uo_out),  32'd0);
        check({tag, ".uio"},     32'(fab_uio_out), 32'd0);
        check({tag, ".oe"},      32'(fab_uio_oe),  32'd0);
        check({tag, ".clk"},     32'(prj_clk),     32'd0);
        check({tag, ".sel"},     32'(active_sel),  32'd0);
        check({tag, ".ui_in"},   32'(prj_ui_in),   32'd0);
        RST_N = 1'b1;
    endtask

    // Expected outputs k cycles after acceptance, built from the phase
    // durations: optional DRAIN, then HOLD, START, ACTIVE (or OFF if invalid).
    function automatic exp_t expect_at(input string tag, input bit from_active,
                                       input int target, input int div, input int k);
        exp_t e;
        bit   ok;
        int   d, h;
        ok = (target < N);
        d  = (from_active || !ok) ? DRAIN_CYC : 0;
        e.tag = tag; e.cyc = k;
        e.ena = '0; e.rstn = '0; e.rstn_chk = 1'b1;
        e.uo = '0; e.uio = '0; e.oe = '0; e.clk = 1'b0;
        e.err = !ok; e.sel = '0; e.sel_chk = 1'b0;
        if (k <= d) begin
            e.busy = 1'b1; e.ready = 1'b0; e.rstn_chk = 1'b0;
        end else if (!ok) begin
            e.busy = 1'b0; e.ready = 1'b1;
        end else begin
            h         = k - d;
            e.sel_chk = 1'b1;
            e.sel     = 4'(target);
            e.clk     = (((h - 1) / (div + 1)) % 2) == 1;
            if (h <= RST_HOLD) begin
                e.busy = 1'b1; e.ready = 1'b0;
            end else if (h == RST_HOLD + 1) begin
                e.busy = 1'b1; e.ready = 1'b0; e.rstn = 4'(1 << target);
            end else begin
                e.busy = 1'b0; e.ready = 1'b1;
                e.ena  = 4'(1 << target);
                e.rstn = 4'(1 << target);
                if (h > RST_HOLD + 2) begin
                    e.uo  = pat_byte(UO_PAT,  target);
                    e.uio = pat_byte(UIO_PAT, target);
                    e.oe  = pat_byte(OE_PAT,  target);
                end
            end
        end
        return e;
    endfunction

    // Issue one request, then hold sel_valid (with alt_req) for valid_hold
    // more cycles and scramble div_cfg, comparing n_cyc cycles of trace.
    task automatic run_switch(input string tag, input bit from_active, input int target,
                              input int div, input int valid_hold, input int alt_req,
                              input int n_cyc);
        exp_t  e;
        string p;
        for (int k = 1; k <= n_cyc; k++)
            sb.push_back(expect_at(tag, from_active, target, div, k));
        sel_req   = SEL_W'(target);
        div_cfg   = DIV_W'(div);
        sel_valid = 1'b1;
        for (int k = 1; k <= n_cyc; k++) begin
            tick();
            e = sb.pop_front();
            p = $sformatf("%s@%0d", e.tag, e.cyc);
            check({p, ".ena"},   32'(prj_ena),     32'(e.ena));
            if (e.rstn_chk) check({p, ".rst_n"}, 32'(prj_rst_n), 32'(e.rstn));
            check({p, ".busy"},  32'(busy),        32'(e.busy));
            check({p, ".ready"}, 32'(sel_ready),   32'(e.ready));
            check({p, ".uo"},    32'(fab_uo_out),  32'(e.uo));
            check({p, ".uio"},   32'(fab_uio_out), 32'(e.uio));
            check({p, ".oe"},    32'(fab_uio_oe),  32'(e.oe));
            check({p, ".clk"},   32'(prj_clk),     32'(e.clk));
            check({p, ".err"},   32'(sel_err),     32'(e.err));
            if (e.sel_chk) check({p, ".sel"}, 32'(active_sel), 32'(e.sel));
            if (k <= valid_hold) begin
                sel_valid = 1'b1;
                sel_req   = SEL_W'(alt_req);
            end else begin
                sel_valid = 1'b0;
            end
            div_cfg = ~DIV_W'(div);
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        sel_valid  = 1'b0;
        sel_req    = '0;
        div_cfg    = '0;
        fab_ui_in  = '0;
        fab_uio_in = '0;
        @(negedge UserCLK);
        apply_reset("reset");

        run_switch("off_p2",   1'b0, 2, 0, 0, 0, 12);
        run_switch("p2_p1",    1'b1, 1, 0, 0, 0, 14);
        run_switch("bad5",     1'b1, 5, 0, 0, 0, 4);
        run_switch("off_p0",   1'b0, 0, 0, 0, 0, 12);
        run_switch("busy_ign", 1'b1, 3, 3, 6, 1, 24);
        run_switch("reselect", 1'b1, 3, 1, 0, 0, 16);
        run_switch("pre_rst",  1'b1, 0, 0, 0, 0, 5);
        apply_reset("rst_hold");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
